// File: rtl/inv_sbox.sv
// AES inverse S-box: combinational 256-entry byte lookup.
module inv_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = INV_SBOX[x];

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: one inverse round per accepted round key,
// keys requested from the shared key expansion unit in order 10 down to 0.
module aes_decrypt_core #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic         key_expansion_done,
    output logic [3:0]   desired_round,
    output logic [127:0] data_out,
    output logic         done
);

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_t         fsm;
    logic [3:0]   round;
    logic [127:0] blk;
    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r: s'[r][c] = s[r][c-r]; byte 4c+r sits at bits [127-8(4c+r)].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a;
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a  = col[31 - 8*i -: 8];
            x2 = xtime(a);
            x4 = xtime(x2);
            x8 = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign shifted = inv_shift_rows(blk);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .x(shifted[8*i +: 8]),
            .y(subbed[8*i +: 8])
        );
    end

    assign keyed = subbed ^ key_in;
    assign mixed = {inv_mix_col(keyed[127:96]), inv_mix_col(keyed[95:64]),
                    inv_mix_col(keyed[63:32]),  inv_mix_col(keyed[31:0])};

    // The round counter is exactly the key index being consumed, so it drives desired_round.
    assign desired_round = round;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= IDLE;
            round    <= LAST_ROUND;
            blk      <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        blk   <= data_in;
                        round <= LAST_ROUND;
                        fsm   <= INIT;
                    end
                end
                INIT: begin
                    if (key_expansion_done) begin
                        blk   <= blk ^ key_in;
                        round <= LAST_ROUND - 4'd1;
                        fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    if (key_expansion_done) begin
                        blk   <= mixed;
                        round <= round - 4'd1;
                        if (round == 4'd1) begin
                            fsm <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    if (key_expansion_done) begin
                        data_out <= keyed;
                        done     <= 1'b1;
                        fsm      <= DONE;
                    end
                end
                DONE: begin
                    round <= LAST_ROUND;
                    fsm   <= IDLE;
                end
                default: begin
                    fsm   <= IDLE;
                    round <= LAST_ROUND;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
- Iterative AES-128 decryption datapath (FIPS-197 inverse cipher), the decrypt-side counterpart of the encryption core.
- Receives a 128-bit ciphertext and produces the 128-bit plaintext.
- Requests round keys from the shared key expansion unit by round index, 10 down to 0, and consumes each round key on a valid qualifier.
- Performs one inverse round per accepted round key.
- Instantiated under a decryption top level beside key_expansion.

Parameters:
NR, 10, number of AES rounds (AES-128 only; other values unsupported)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begin decryption of data_in
data_in  input  128  ciphertext; sampled only on the cycle start is accepted
key_in  input  128  round key for the index currently on desired_round
key_expansion_done  input  1  key_in is valid for the current desired_round in this cycle
desired_round  output  4  round key index requested
data_out  output  128  plaintext; valid from the done pulse until the next accepted start
done  output  1  one-cycle pulse when data_out is updated

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Byte order: byte 0 = bits [127:120]. Bytes fill the state column-major: s[r][c] = byte 4c+r, as in FIPS-197.
- Reset values:
  - state = IDLE
  - desired_round = 4'd10
  - data_out = 0
  - done = 0
  - internal state register = 0
  - round counter = 10
- FSM: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - desired_round = 10.
  - When start = 1, latch data_in into the state register, set round = 10 and go to INIT.
  - start is ignored in every other state; there is no abort.
- INIT:
  - Wait for key_expansion_done = 1.
  - On that cycle: state <= state ^ key_in (AddRoundKey with K10), round <= 9, go to ROUND.
- ROUND (round = 9..1), desired_round = round:
  - Wait for key_expansion_done = 1.
  - On that cycle: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), key_in)) and round <= round-1.
  - If the new round = 0, go to FINAL.
- FINAL, desired_round = 0:
  - Wait for key_expansion_done = 1.
  - On that cycle: data_out <= AddRoundKey(InvSubBytes(InvShiftRows(state)), key_in), go to DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - desired_round returns to 10 and the FSM returns to IDLE on the next edge.
  - A start in the DONE cycle is ignored.
- desired_round always equals the index of the key the current state consumes. It changes only on the edge that consumes a key.
- Key-source contract: key_expansion_done qualifies key_in against the desired_round value driven in the same cycle.
- Stalls: any cycle in INIT, ROUND or FINAL with key_expansion_done = 0 holds all registers.
- Latency with key_expansion_done tied high:
  - start accepted at edge 0.
  - INIT at edge 1, rounds 9..1 at edges 2..10, FINAL at edge 11.
  - done is high in the cycle after edge 11, i.e. 12 cycles after start is sampled.
- InvShiftRows: row r rotates right by r bytes.
- InvMixColumns: matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial x^8+x^4+x^3+x+1. Implemented with the xtime chain; no multipliers.
- InvSubBytes: 16 instances of the team's inv_sbox byte LUT, combinational, in a separate file.
- Reset mid-operation: on the next edge, return to IDLE with all reset values. No done pulse is produced.
- data_out holds the last plaintext until the next completed operation.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a, behavioural key model with ready tied high -> data_out = 00112233445566778899aabbccddeeff; done exactly 12 cycles after start; desired_round sequence 10,9,...,1,0.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32, key model inserting random 0-5 cycle stalls per round -> data_out = 3243f6a8885a308d313198a2e0370734; desired_round held during each stall; no state change while key_expansion_done = 0.
- Back-to-back: both vectors above, second start issued the cycle after DONE -> two correct results, exactly two done pulses; data_out stable between them.
- start pulsed during ROUND with a different data_in -> ignored; the first result is still correct.
- Reset asserted while round = 5 -> next cycle data_out = 0, done = 0, desired_round = 10, FSM in IDLE; a fresh C.1 run afterwards decrypts correctly.
- Round-trip: 1000 random key/plaintext pairs encrypted by the encryption top, ciphertext fed to this block -> every data_out equals the original plaintext.
